mmio_router: RTL

Parametrised memory-mapped I/O router between the Vicuna/Ibex data bus and on-chip peripherals: a GPIO bank of configurable width, a bank of digital-timer channels, and the SRAM/external storage controller. Every access uses an explicit grant/response handshake and receives exactly one response. Added over the previous fixed decoder:

- Storage timeout.
- Byte-enable-aware registers.
- Set/clear GPIO registers.
- Synchronised GPIO inputs.
- Split pin ports instead of `inout`.

---
 rtl/mmio_router.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mmio_router.sv
// rtl/mmio_router.sv - MMIO router: GPIO bank, timer channels and storage port behind a grant/response bus
module mmio_router #(
    parameter int MEM_W        = 32,
    parameter int GPIO_N       = 16,
    parameter int TIMER_N      = 2,
    parameter int STOR_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_req_i,
    output logic                 mem_gnt_o,
    input  logic [31:0]          mem_addr_i,
    input  logic                 mem_we_i,
    input  logic [MEM_W/8-1:0]   mem_be_i,
    input  logic [MEM_W-1:0]     mem_wdata_i,
    output logic                 mem_rvalid_o,
    output logic                 mem_err_o,
    output logic [MEM_W-1:0]     mem_rdata_o,
    output logic                 stor_req_o,
    output logic                 stor_we_o,
    output logic [31:0]          stor_addr_o,
    output logic [MEM_W/8-1:0]   stor_be_o,
    output logic [MEM_W-1:0]     stor_wdata_o,
    input  logic [MEM_W-1:0]     stor_rdata_i,
    input  logic                 stor_valid_i,
    output logic                 stor_abort_o,
    input  logic [TIMER_N-1:0]   timer_is_high_i,
    output logic [31:0]          timer_set_val_o,
    output logic [TIMER_N-1:0]   set_timer_o,
    input  logic [GPIO_N-1:0]    gpio_in_i,
    output logic [GPIO_N-1:0]    gpio_out_o,
    output logic [GPIO_N-1:0]    gpio_oe_o
);
    localparam int BE_W  = MEM_W / 8;
    localparam int CNT_W = $clog2(STOR_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REG_RESP, S_STOR_WAIT, S_STOR_RESP} state_e;

    state_e               state_q, state_d;
    logic [GPIO_N-1:0]    dir_q, dir_d, out_q, out_d, sync1_q, sync2_q;
    logic [MEM_W-1:0]     rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 stor_we_q, stor_we_d;
    logic [31:0]          stor_addr_q, stor_addr_d;
    logic [BE_W-1:0]      stor_be_q, stor_be_d;
    logic [MEM_W-1:0]     stor_wdata_q, stor_wdata_d;
    logic                 abort_q, abort_d;
    logic [TIMER_N-1:0]   set_timer_q, set_timer_d;
    logic [31:0]          timer_val_q, timer_val_d;

    logic        hit_dir, hit_out, hit_in, hit_set, hit_clr, hit_timer, hit_sram, hit_ext, stor_ok;
    logic [31:0] timer_off;
    logic        timer_bit;
    logic [31:0] be_mask;
    logic [GPIO_N-1:0] wmask, wbits;

    assign hit_dir   = (mem_addr_i == 32'h100);
    assign hit_out   = (mem_addr_i == 32'h104);
    assign hit_in    = (mem_addr_i == 32'h108);
    assign hit_set   = (mem_addr_i == 32'h10C);
    assign hit_clr   = (mem_addr_i == 32'h110);
    assign timer_off = mem_addr_i - 32'h200;
    assign hit_timer = (mem_addr_i >= 32'h200) && (timer_off[31:2] < 30'(TIMER_N))
                       && (mem_addr_i[1:0] == 2'b00);
    assign hit_sram  = (mem_addr_i >= 32'h1000) && (mem_addr_i < 32'h2000);
    assign hit_ext   = (mem_addr_i >= 32'h2000);
    // External storage is read-only; such writes fall through to the error path
    assign stor_ok   = hit_sram || (hit_ext && !mem_we_i);

    assign be_mask = {{8{mem_be_i[3]}}, {8{mem_be_i[2]}}, {8{mem_be_i[1]}}, {8{mem_be_i[0]}}};
    assign wmask   = GPIO_N'(be_mask);
    assign wbits   = GPIO_N'(mem_wdata_i) & wmask;

    always_comb begin
        timer_bit   = 1'b0;
        set_timer_d = '0;
        for (int k = 0; k < TIMER_N; k++) begin
            if (timer_off[31:2] == 30'(k)) begin
                timer_bit      = timer_is_high_i[k];
                set_timer_d[k] = (state_q == S_IDLE) && mem_req_i && mem_we_i && hit_timer;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        out_d        = out_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        stor_we_d    = stor_we_q;
        stor_addr_d  = stor_addr_q;
        stor_be_d    = stor_be_q;
        stor_wdata_d = stor_wdata_q;
        abort_d      = 1'b0;
        timer_val_d  = timer_val_q;
        case (state_q)
            S_IDLE: begin
                if (mem_req_i) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (stor_ok) begin
                        state_d      = S_STOR_WAIT;
                        cnt_d        = '0;
                        stor_we_d    = mem_we_i;
                        stor_addr_d  = mem_addr_i;
                        stor_be_d    = mem_be_i;
                        stor_wdata_d = mem_wdata_i;
                    end else begin
                        state_d = S_REG_RESP;
                        if (hit_dir) begin
                            if (mem_we_i) dir_d = (dir_q & ~wmask) | wbits;
                            else          rdata_d = MEM_W'(dir_q);
                        end else if (hit_out) begin
                            if (mem_we_i) out_d = (out_q & ~wmask) | wbits;
                            else          rdata_d = MEM_W'(out_q);
                        end else if (hit_in) begin
                            if (mem_we_i) err_d = 1'b1;
                            else          rdata_d = MEM_W'(sync2_q);
                        end else if (hit_set) begin
                            if (mem_we_i) out_d = out_q | wbits;
                        end else if (hit_clr) begin
                            if (mem_we_i) out_d = out_q & ~wbits;
                        end else if (hit_timer) begin
                            if (mem_we_i) timer_val_d = 32'(mem_wdata_i);
                            else          rdata_d = MEM_W'(timer_bit);
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            S_STOR_WAIT: begin
                // A valid arriving on the last wait cycle beats the timeout
                if (stor_valid_i) begin
                    state_d = S_STOR_RESP;
                    rdata_d = stor_we_q ? '0 : stor_rdata_i;
                end else if (cnt_q == CNT_W'(STOR_TIMEOUT - 1)) begin
                    state_d = S_STOR_RESP;
                    err_d   = 1'b1;
                    abort_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_REG_RESP, S_STOR_RESP: state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            dir_q        <= '0;
            out_q        <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            stor_we_q    <= 1'b0;
            stor_addr_q  <= '0;
            stor_be_q    <= '0;
            stor_wdata_q <= '0;
            abort_q      <= 1'b0;
            set_timer_q  <= '0;
            timer_val_q  <= '0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            out_q        <= out_d;
            sync1_q      <= gpio_in_i;
            sync2_q      <= sync1_q;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            stor_we_q    <= stor_we_d;
            stor_addr_q  <= stor_addr_d;
            stor_be_q    <= stor_be_d;
            stor_wdata_q <= stor_wdata_d;
            abort_q      <= abort_d;
            set_timer_q  <= set_timer_d;
            timer_val_q  <= timer_val_d;
        end
    end

    assign mem_gnt_o       = (state_q == S_IDLE);
    assign mem_rvalid_o    = (state_q == S_REG_RESP) || (state_q == S_STOR_RESP);
    assign mem_err_o       = mem_rvalid_o && err_q;
    assign mem_rdata_o     = mem_rvalid_o ? rdata_q : '0;
    assign stor_req_o      = (state_q == S_STOR_WAIT);
    assign stor_we_o       = stor_we_q;
    assign stor_addr_o     = stor_addr_q;
    assign stor_be_o       = stor_be_q;
    assign stor_wdata_o    = stor_wdata_q;
    assign stor_abort_o    = abort_q;
    assign timer_set_val_o = timer_val_q;
    assign set_timer_o     = set_timer_q;
    assign gpio_out_o      = out_q;
    assign gpio_oe_o       = dir_q;
endmodule
